// File: rtl/branch_resolve_unit_pkg.sv
// Shared types and encodings for the branch resolve unit: FSM states,
// RV32 control-transfer opcodes and conditional-branch funct3 codes.
package branch_resolve_unit_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    SQUASH   = 2'd2
  } bru_state_e;

  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Fetch only accepts word-aligned redirect targets.
  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_cond_eval.sv
// Combinational taken/not-taken decision for the EX-stage instruction,
// built from the compare block's breq/brlt flags.
module branch_cond_eval
  import branch_resolve_unit_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       breq,
  input  logic       brlt,
  output logic       taken,
  output logic       is_branch,
  output logic       illegal
);

  always_comb begin
    taken     = 1'b0;
    is_branch = 1'b0;
    illegal   = 1'b0;
    case (opcode)
      OPCODE_BRANCH: begin
        is_branch = 1'b1;
        case (funct3)
          F3_BEQ:           taken = breq;
          F3_BNE:           taken = ~breq;
          F3_BLT, F3_BLTU:  taken = brlt;
          F3_BGE, F3_BGEU:  taken = ~brlt;
          default:          illegal = 1'b1;
        endcase
      end
      OPCODE_JAL, OPCODE_JALR: taken = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches/jumps, drives a registered redirect handshake to
// fetch and holds a flush window so younger IF/ID instructions get squashed.
module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int AWIDTH       = 32,
  parameter int DWIDTH       = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] imm_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic              breq_i,
  input  logic              brlt_i,
  input  logic              redirect_ready_i,
  output logic              redirect_valid_o,
  output logic [AWIDTH-1:0] redirect_pc_o,
  output logic              flush_o,
  output logic              stall_o,
  output logic              illegal_o,
  output logic              misalign_o,
  output logic [CNT_W-1:0]  branch_count_o,
  output logic [CNT_W-1:0]  taken_count_o
);

  localparam int SQW = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [SQW-1:0] SQ_LOAD = SQW'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

  bru_state_e        state_reg, state_next;
  logic [SQW-1:0]    sq_cnt_reg;
  logic [AWIDTH-1:0] redirect_pc_reg;
  logic              illegal_reg, misalign_reg;
  logic [CNT_W-1:0]  branch_count_reg, taken_count_reg;

  logic cond_taken, cond_is_branch, cond_illegal;

  branch_cond_eval u_cond_eval (
    .opcode    (opcode_i),
    .funct3    (funct3_i),
    .breq      (breq_i),
    .brlt      (brlt_i),
    .taken     (cond_taken),
    .is_branch (cond_is_branch),
    .illegal   (cond_illegal)
  );

  // Immediate is sign-extended and rs1 zero-extended when narrower than a PC.
  logic [AWIDTH-1:0] imm_ext, rs1_ext;
  generate
    if (DWIDTH >= AWIDTH) begin : g_trunc
      assign imm_ext = imm_i[AWIDTH-1:0];
      assign rs1_ext = rs1_i[AWIDTH-1:0];
    end else begin : g_extend
      assign imm_ext = {{(AWIDTH-DWIDTH){imm_i[DWIDTH-1]}}, imm_i};
      assign rs1_ext = {{(AWIDTH-DWIDTH){1'b0}}, rs1_i};
    end
  endgenerate

  logic              is_jalr;
  logic [AWIDTH-1:0] target_base, target_sum, target;

  assign is_jalr     = (opcode_i == OPCODE_JALR);
  assign target_base = is_jalr ? rs1_ext : pc_i;
  assign target_sum  = target_base + imm_ext;
  assign target      = {target_sum[AWIDTH-1:1], target_sum[0] & ~is_jalr};

  logic accept, redirect_go, misalign_go, handshake;

  assign accept      = (state_reg == IDLE) && valid_i;
  assign redirect_go = accept && cond_taken && is_word_aligned(target[1:0]);
  assign misalign_go = accept && cond_taken && !is_word_aligned(target[1:0]);
  assign handshake   = (state_reg == REDIRECT) && redirect_ready_i;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (redirect_go) state_next = REDIRECT;
      end
      REDIRECT: begin
        if (handshake) state_next = (FLUSH_CYCLES == 0) ? IDLE : SQUASH;
      end
      SQUASH: begin
        if (sq_cnt_reg == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from the registered state
  always_comb begin
    redirect_valid_o = 1'b0;
    flush_o          = 1'b0;
    stall_o          = 1'b0;
    case (state_reg)
      REDIRECT: begin
        redirect_valid_o = 1'b1;
        flush_o          = 1'b1;
        stall_o          = 1'b1;
      end
      SQUASH:  flush_o = 1'b1;
      default: ;
    endcase
  end

  // Datapath: target latch, squash counter, error pulses, statistics
  always_ff @(posedge clk) begin
    if (reset) begin
      sq_cnt_reg       <= '0;
      redirect_pc_reg  <= '0;
      illegal_reg      <= 1'b0;
      misalign_reg     <= 1'b0;
      branch_count_reg <= '0;
      taken_count_reg  <= '0;
    end else begin
      if (handshake) begin
        sq_cnt_reg <= SQ_LOAD;
      end else if (state_reg == SQUASH && sq_cnt_reg != '0) begin
        sq_cnt_reg <= sq_cnt_reg - SQW'(1);
      end
      if (redirect_go) redirect_pc_reg <= target;
      illegal_reg  <= accept && cond_is_branch && cond_illegal;
      misalign_reg <= misalign_go;
      if (accept && cond_is_branch) begin
        branch_count_reg <= branch_count_reg + CNT_W'(1);
        if (cond_taken) taken_count_reg <= taken_count_reg + CNT_W'(1);
      end
    end
  end

  assign redirect_pc_o  = redirect_pc_reg;
  assign illegal_o      = illegal_reg;
  assign misalign_o     = misalign_reg;
  assign branch_count_o = branch_count_reg;
  assign taken_count_o  = taken_count_reg;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: redirect targets go through a
// scoreboard queue, flush/stall/pulse/counter behaviour is checked directly.
`timescale 1ns/1ps
module tb_branch_resolve_unit;

  localparam logic [6:0] OPC_BR   = 7'b1100011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_ALU  = 7'b0110011;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic [31:0] pc_i, imm_i, rs1_i;
  logic        breq_i, brlt_i, redirect_ready_i;
  logic        redirect_valid_o, flush_o, stall_o, illegal_o, misalign_o;
  logic [31:0] redirect_pc_o, branch_count_o, taken_count_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned exp_br   = 0;
  int unsigned exp_tk   = 0;
  logic [31:0] sb_q[$];

  always #5 clk = ~clk;

  branch_resolve_unit #(
    .AWIDTH(32), .DWIDTH(32), .FLUSH_CYCLES(2), .CNT_W(32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .valid_i          (valid_i),
    .opcode_i         (opcode_i),
    .funct3_i         (funct3_i),
    .pc_i             (pc_i),
    .imm_i            (imm_i),
    .rs1_i            (rs1_i),
    .breq_i           (breq_i),
    .brlt_i           (brlt_i),
    .redirect_ready_i (redirect_ready_i),
    .redirect_valid_o (redirect_valid_o),
    .redirect_pc_o    (redirect_pc_o),
    .flush_o          (flush_o),
    .stall_o          (stall_o),
    .illegal_o        (illegal_o),
    .misalign_o       (misalign_o),
    .branch_count_o   (branch_count_o),
    .taken_count_o    (taken_count_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Scoreboard consumer: every accepted redirect must match the oldest expected target.
  always @(negedge clk) begin
    if (!reset && redirect_valid_o && redirect_ready_i) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_redirect", {32'd0, redirect_pc_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [31:0] exp_pc;
        exp_pc = sb_q.pop_front();
        check_eq("sb_redirect_pc", {32'd0, redirect_pc_o}, {32'd0, exp_pc});
        $display("redirect accepted pc=0x%08h expected=0x%08h", redirect_pc_o, exp_pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] pc,
                          input logic [31:0] imm, input logic [31:0] rs1,
                          input logic eq, input logic lt);
    valid_i  = 1'b1;
    opcode_i = opc;
    funct3_i = f3;
    pc_i     = pc;
    imm_i    = imm;
    rs1_i    = rs1;
    breq_i   = eq;
    brlt_i   = lt;
    $display("ex opc=%b f3=%b pc=0x%08h imm=0x%08h rs1=0x%08h breq=%0b brlt=%0b",
             opc, f3, pc, imm, rs1, eq, lt);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((redirect_valid_o || flush_o) && n < 50) begin
      redirect_ready_i = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    redirect_ready_i = 1'b1;
    check_eq("idle_wait", {62'd0, redirect_valid_o, flush_o}, 64'd0);
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_br_cnt"}, {32'd0, branch_count_o}, {32'd0, exp_br});
    check_eq({tag, "_tk_cnt"}, {32'd0, taken_count_o}, {32'd0, exp_tk});
  endtask

  function automatic logic ref_taken(input logic [2:0] f3, input logic eq, input logic lt);
    case (f3)
      3'b000:         return eq;
      3'b001:         return !eq;
      3'b100, 3'b110: return lt;
      3'b101, 3'b111: return !lt;
      default:        return 1'b0;
    endcase
  endfunction

  initial begin
    logic [2:0]  f3_tab [6];
    logic [2:0]  f3;
    logic        eq, lt, tk;
    logic [31:0] pc, imm;

    f3_tab = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    reset = 1'b1; valid_i = 1'b0; opcode_i = '0; funct3_i = '0;
    pc_i = '0; imm_i = '0; rs1_i = '0; breq_i = 1'b0; brlt_i = 1'b0;
    redirect_ready_i = 1'b0;
    repeat (3) tick();
    check_eq("rst_outputs", {59'd0, redirect_valid_o, flush_o, stall_o, illegal_o, misalign_o}, 64'd0);
    check_eq("rst_pc", {32'd0, redirect_pc_o}, 64'd0);
    check_counts("rst");
    reset = 1'b0;
    redirect_ready_i = 1'b1;
    tick();

    // 1: BEQ taken, ready high in first REDIRECT cycle
    sb_q.push_back(32'h120); exp_br++; exp_tk++;
    drive_ex(OPC_BR, 3'b000, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0);
    check_eq("t1_redirect", {61'd0, redirect_valid_o, flush_o, stall_o}, 64'b111);
    check_eq("t1_pc", {32'd0, redirect_pc_o}, 64'h120);
    tick();
    check_eq("t1_squash1", {61'd0, redirect_valid_o, flush_o, stall_o}, 64'b010);
    tick();
    check_eq("t1_squash2", {61'd0, redirect_valid_o, flush_o, stall_o}, 64'b010);
    tick();
    check_eq("t1_idle", {61'd0, redirect_valid_o, flush_o, stall_o}, 64'b000);
    check_counts("t1");

    // 2: BNE with breq=1 is not taken
    exp_br++;
    drive_ex(OPC_BR, 3'b001, 32'h200, 32'h20, 32'h0, 1'b1, 1'b0);
    check_eq("t2_no_redirect", {62'd0, redirect_valid_o, flush_o}, 64'd0);
    check_counts("t2");

    // 3: JALR clears bit 0 of rs1+imm; counters untouched
    sb_q.push_back(32'h2004);
    drive_ex(OPC_JALR, 3'b000, 32'h400, 32'h3, 32'h2001, 1'b0, 1'b0);
    check_eq("t3_valid", {63'd0, redirect_valid_o}, 64'd1);
    check_eq("t3_pc", {32'd0, redirect_pc_o}, 64'h2004);
    wait_idle();
    check_counts("t3");

    // JAL target wraps modulo 2^32
    sb_q.push_back(32'h10);
    drive_ex(OPC_JAL, 3'b000, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 1'b0);
    check_eq("jal_wrap_pc", {32'd0, redirect_pc_o}, 64'h10);
    wait_idle();

    // Non-branch opcode: nothing happens
    drive_ex(OPC_ALU, 3'b000, 32'h500, 32'h8, 32'h0, 1'b1, 1'b1);
    check_eq("alu_quiet", {60'd0, redirect_valid_o, flush_o, illegal_o, misalign_o}, 64'd0);
    check_counts("alu");

    // 4: BLT taken, fetch stalls 3 cycles, a new EX BEQ is ignored meanwhile
    redirect_ready_i = 1'b0;
    sb_q.push_back(32'h140); exp_br++; exp_tk++;
    drive_ex(OPC_BR, 3'b100, 32'h100, 32'h40, 32'h0, 1'b0, 1'b1);
    valid_i = 1'b1; opcode_i = OPC_BR; funct3_i = 3'b000; breq_i = 1'b1;
    pc_i = 32'h800; imm_i = 32'h100;
    for (int i = 0; i < 3; i++) begin
      check_eq("t4_hold", {61'd0, redirect_valid_o, flush_o, stall_o}, 64'b111);
      check_eq("t4_hold_pc", {32'd0, redirect_pc_o}, 64'h140);
      tick();
    end
    valid_i = 1'b0;
    redirect_ready_i = 1'b1;
    check_eq("t4_still_valid", {63'd0, redirect_valid_o}, 64'd1);
    tick();
    check_eq("t4_squash1", {61'd0, redirect_valid_o, flush_o, stall_o}, 64'b010);
    tick();
    check_eq("t4_squash2", {61'd0, redirect_valid_o, flush_o, stall_o}, 64'b010);
    tick();
    check_eq("t4_idle", {62'd0, redirect_valid_o, flush_o}, 64'd0);
    check_counts("t4");

    // 5: illegal funct3 and misaligned target
    exp_br++;
    drive_ex(OPC_BR, 3'b010, 32'h100, 32'h20, 32'h0, 1'b1, 1'b1);
    check_eq("t5_illegal", {61'd0, illegal_o, redirect_valid_o, flush_o}, 64'b100);
    tick();
    check_eq("t5_illegal_clr", {63'd0, illegal_o}, 64'd0);
    exp_br++; exp_tk++;
    drive_ex(OPC_BR, 3'b000, 32'h100, 32'h2, 32'h0, 1'b1, 1'b0);
    check_eq("t5_misalign", {61'd0, misalign_o, redirect_valid_o, flush_o}, 64'b100);
    tick();
    check_eq("t5_misalign_clr", {63'd0, misalign_o}, 64'd0);
    check_counts("t5");

    // Random conditional branches, aligned targets, random fetch backpressure
    for (int k = 0; k < 12; k++) begin
      f3  = f3_tab[$urandom_range(0, 5)];
      eq  = 1'($urandom_range(0, 1));
      lt  = 1'($urandom_range(0, 1));
      pc  = $urandom() & 32'hFFFF_FFFC;
      imm = 32'($urandom_range(0, 1023)) << 2;
      tk  = ref_taken(f3, eq, lt);
      exp_br++;
      if (tk) begin
        exp_tk++;
        sb_q.push_back(pc + imm);
      end
      drive_ex(OPC_BR, f3, pc, imm, 32'h0, eq, lt);
      check_eq("rnd_taken", {63'd0, redirect_valid_o}, {63'd0, tk});
      wait_idle();
    end
    check_counts("rnd");
    check_eq("sb_drained", 64'(sb_q.size()), 64'd0);

    // 6: reset while in REDIRECT
    redirect_ready_i = 1'b0;
    drive_ex(OPC_BR, 3'b000, 32'h300, 32'h10, 32'h0, 1'b1, 1'b0);
    check_eq("t6_in_redirect", {63'd0, redirect_valid_o}, 64'd1);
    reset = 1'b1;
    tick();
    check_eq("t6_outputs", {59'd0, redirect_valid_o, flush_o, stall_o, illegal_o, misalign_o}, 64'd0);
    check_eq("t6_pc", {32'd0, redirect_pc_o}, 64'd0);
    exp_br = 0; exp_tk = 0;
    check_counts("t6");
    reset = 1'b0;
    tick();
    check_eq("t6_idle_after", {62'd0, redirect_valid_o, flush_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
